// File: rtl/interp_tap_accum_if.sv
// interp_tap_accum_if
// Bundles the tap-product input stream, the sample output stream and the
// group-length error pulse of interp_tap_accum.
//   in_valid / in_ready / in_prod / in_last : tap product beats (producer -> block)
//   out_valid / out_ready / out_sample      : clipped samples (block -> consumer)
//   err_len                                 : one-cycle group length violation pulse
// Modports: master = producer/consumer side (testbench), slave = the accumulator.
interface interp_tap_accum_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_prod;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_sample;
    logic                    err_len;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sample, err_len
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sample, err_len
    );
endinterface

// File: rtl/interp_tap_accum.sv
// interp_tap_accum
// Serial accumulator closing the fractional-sample interpolation path. Sums
// NTAPS signed tap products per output sample, rounds, normalises by 2^SHIFT,
// clips to [0, 2^OUT_W-1] and queues the result in a 2-entry output FIFO.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : interp_tap_accum_if.slave (input beats, output samples, err_len)
// A group whose in_last marker disagrees with the tap count is dropped and
// flagged on err_len in the following cycle.
module interp_tap_accum #(
    parameter int NTAPS = 8,
    parameter int IN_W  = 32,
    parameter int ACC_W = 36,
    parameter int SHIFT = 6,
    parameter int OUT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    interp_tap_accum_if.slave     bus
);

    localparam int CNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
    localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    // Half an output LSB, added before the arithmetic shift for round-half-up.
    localparam logic signed [ACC_W-1:0] RND_C    = ACC_W'(1'b1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX  = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // Clamp a normalised accumulator value into the unsigned sample range.
    function automatic logic [OUT_W-1:0] clip_sample(input logic signed [ACC_W-1:0] r);
        logic [OUT_W-1:0] res;
        if (r[ACC_W-1]) begin
            res = {OUT_W{1'b0}};
        end else if (r > OUT_MAX) begin
            res = {OUT_W{1'b1}};
        end else begin
            res = r[OUT_W-1:0];
        end
        return res;
    endfunction

    logic [CNT_W-1:0]        cnt_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [OUT_W-1:0]        mem_r [2];
    logic                    wr_ptr_r;
    logic                    rd_ptr_r;
    logic [1:0]              fcnt_r;
    logic                    err_r;

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    at_last_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] rnd_s;
    logic signed [ACC_W-1:0] r_s;
    logic [OUT_W-1:0]        sample_s;
    logic                    push_s;
    logic                    err_s;
    logic                    pop_s;
    logic [CNT_W-1:0]        cnt_nxt_s;

    // Handshakes, running sum, rounding/clipping and group-length decode.
    always_comb begin
        in_ready_s = (fcnt_r < 2'd2);
        accept_s   = bus.in_valid && in_ready_s;
        at_last_s  = (cnt_r == CNT_LAST);
        prod_ext_s = {{(ACC_W-IN_W){bus.in_prod[IN_W-1]}}, bus.in_prod};
        // The first tap of a group ignores whatever is left in acc_r.
        if (cnt_r == CNT_ZERO) begin
            base_s = ACC_ZERO;
        end else begin
            base_s = acc_r;
        end
        sum_s    = base_s + prod_ext_s;
        rnd_s    = sum_s + RND_C;
        r_s      = rnd_s >>> SHIFT;
        sample_s = clip_sample(r_s);
        push_s   = accept_s && bus.in_last && at_last_s;
        err_s    = accept_s && (bus.in_last != at_last_s);
        pop_s    = (fcnt_r != 2'd0) && bus.out_ready;
        if (!accept_s) begin
            cnt_nxt_s = cnt_r;
        end else if (push_s || err_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Tap counter, accumulator and error pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
            acc_r <= ACC_ZERO;
            err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            err_r <= err_s;
            if (accept_s) begin
                acc_r <= sum_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Two-entry output FIFO; push is only possible while not full, so a
    // simultaneous push and pop never collides on the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= {OUT_W{1'b0}};
            mem_r[1] <= {OUT_W{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            fcnt_r   <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sample_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fcnt_r <= fcnt_r + 2'd1;
                2'b01:   fcnt_r <= fcnt_r - 2'd1;
                default: fcnt_r <= fcnt_r;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = (fcnt_r != 2'd0);
    assign bus.out_sample = mem_r[rd_ptr_r];
    assign bus.err_len    = err_r;

endmodule

// File: tb/tb_interp_tap_accum.sv
// tb_interp_tap_accum
// Scoreboard bench: stimulus tasks push reference samples into a queue as
// each complete group is accepted; an independent monitor pops and compares
// whenever the block hands over a sample, and counts err_len cycles.
module tb_interp_tap_accum;

    typedef logic signed [31:0] beats_t [8];

    logic clk;
    logic rst;

    interp_tap_accum_if #(.IN_W(32), .OUT_W(10)) bus ();

    interp_tap_accum #(
        .NTAPS(8), .IN_W(32), .ACC_W(36), .SHIFT(6), .OUT_W(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     nvec     = 0;
    int     nerr     = 0;
    int     exp_err  = 0;
    int     seen_err = 0;
    longint expq [$];
    bit     rand_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: round half up, floor-divide by 64, clamp to 10-bit range.
    function automatic longint ref_sample(input longint sum);
        longint num;
        longint r;
        num = sum + 64'sd32;
        if (num >= 0) r = num / 64'sd64;
        else          r = -((-num + 64'sd63) / 64'sd64);
        if (r < 0)    r = 0;
        if (r > 1023) r = 1023;
        return r;
    endfunction

    function automatic beats_t single(input logic signed [31:0] s);
        beats_t p;
        for (int i = 0; i < 8; i++) p[i] = 32'sd0;
        p[0] = s;
        return p;
    endfunction

    // Monitor: compare every handed-over sample and count err_len cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.err_len) seen_err++;
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_out: got sample %0d, expected none", bus.out_sample);
                end else begin
                    check("out_sample", longint'(bus.out_sample), expq.pop_front());
                end
            end
        end
    end

    task automatic send_beat(input logic signed [31:0] p, input logic lst);
        bit ok = 1'b0;
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        bus.in_last  = lst;
        while (!ok && waited < 2000) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    task automatic good_group(input beats_t p);
        longint s = 0;
        for (int i = 0; i < 8; i++) begin
            s += longint'(p[i]);
            send_beat(p[i], i == 7);
        end
        expq.push_back(ref_sample(s));
    endtask

    task automatic bad_early(input int k);
        for (int i = 0; i < k; i++) send_beat(32'sd1000 * (i + 1), i == k - 1);
        exp_err++;
    endtask

    task automatic bad_nolast();
        for (int i = 0; i < 8; i++) send_beat(32'sd500, 1'b0);
        exp_err++;
    endtask

    longint rsum  [8] = '{95, 96, -33, 70000, -640, 65471, 65440, 65439};
    longint rexp  [8] = '{1, 2, 0, 1023, 0, 1023, 1023, 1022};

    initial begin
        beats_t hp;
        beats_t rp;
        int t;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_prod   = 32'sd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sample", bus.out_sample, 0);
        check("rst_err_len", bus.err_len, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Half-pel group, one-cycle latency.
        hp = '{-32'sd100, 32'sd400, -32'sd1100, 32'sd4000, 32'sd4000, -32'sd1100, 32'sd400, -32'sd100};
        good_group(hp);
        check("halfpel_valid", bus.out_valid, 1);
        check("halfpel_sample", bus.out_sample, 100);
        check("halfpel_err", bus.err_len, 0);
        @(posedge clk);
        #1;

        // Rounding and clipping boundaries.
        for (int i = 0; i < 8; i++) begin
            good_group(single(32'(rsum[i])));
            check($sformatf("bound_%0d", rsum[i]), bus.out_sample, rexp[i]);
        end
        @(posedge clk);
        #1;

        // Early in_last: pulse next cycle, nothing emitted.
        bad_early(3);
        check("early_err", bus.err_len, 1);
        check("early_noout", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("early_err_one_cycle", bus.err_len, 0);
        check("early_noout2", bus.out_valid, 0);
        good_group(single(32'sd640));
        check("after_err_sample", bus.out_sample, 10);
        @(posedge clk);
        #1;
        bad_nolast();
        check("nolast_err", bus.err_len, 1);
        check("nolast_noout", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Backpressure: two results fill the FIFO, third group stalls.
        bus.out_ready = 1'b0;
        good_group(single(32'sd640));
        good_group(single(32'sd1280));
        check("bp_in_ready_low", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_prod  = 32'sd1920;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_stall", bus.in_ready, 0);
        check("bp_head_stable", bus.out_sample, 10);
        bus.out_ready = 1'b1;
        good_group(single(32'sd1920));
        t = 0;
        while (expq.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_drain", expq.size(), 0);

        // Asynchronous reset mid-group with a buffered result.
        bus.out_ready = 1'b0;
        good_group(single(32'sd640));
        for (int i = 0; i < 4; i++) send_beat(32'sd100, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_out_sample", bus.out_sample, 0);
        expq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_quiet", bus.out_valid, 0);
        good_group(single(32'sd4928));
        check("arst_fresh", bus.out_sample, 77);
        @(posedge clk);
        #1;

        // Randomised groups with random downstream stalls and length errors.
        fork
            begin
                for (int g = 0; g < 60; g++) begin
                    int kind;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    kind = int'($urandom_range(0, 9));
                    for (int i = 0; i < 8; i++) begin
                        if (kind == 9) rp[i] = $signed($urandom) >>> $urandom_range(0, 8);
                        else           rp[i] = int'($urandom_range(0, 20000)) - 4000;
                    end
                    if (kind == 0)      bad_early(int'($urandom_range(1, 7)));
                    else if (kind == 1) bad_nolast();
                    else                good_group(rp);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;

        t = 0;
        while (expq.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("final_drain", expq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", bus.out_valid, 0);
        check("err_count", seen_err, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
